// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: memory-wait, multi-cycle divide, redirect and
// load-use stall/flush generation, plus timeout flag and stall counter.
module pipeline_ctrl #(
    parameter int unsigned DIV_LAT     = 8,
    parameter int unsigned MEM_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_div_valid,
    input  logic        ex_redirect,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mem_wb_flush,
    output logic        div_start,
    output logic        div_done,
    output logic        busy,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        RUN = 1'b0,
        DIV = 1'b1
    } state_t;

    localparam logic [7:0]  CNT_INIT = 8'(DIV_LAT - 1);
    localparam logic [15:0] TMO      = 16'(MEM_TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_wcnt;
    logic        r_mem_err;
    logic [31:0] r_stall_cycles;

    logic w_mstall;
    logic w_div_hold;
    logic w_load_use;

    assign w_mstall   = dmem_req & ~dmem_ready;
    assign w_div_hold = ((r_state == RUN) & ex_div_valid) |
                        ((r_state == DIV) & (r_cnt != '0));
    assign w_load_use = ex_mem_read & (ex_rd != '0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    // Outputs are gated by reset so they drop the instant reset asserts.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        div_start    = 1'b0;
        div_done     = 1'b0;
        if (!reset) begin
            pc_stall = 1'b0;
        end else if (w_mstall) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (w_div_hold) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            div_start    = (r_state == RUN);
        end else begin
            div_done = (r_state == DIV);
            if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign busy         = (r_state == DIV);
    assign mem_err      = r_mem_err;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= RUN;
            r_cnt          <= '0;
            r_wcnt         <= '0;
            r_mem_err      <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (w_mstall) begin
                if (r_wcnt != TMO)
                    r_wcnt <= r_wcnt + 16'd1;
                // Flag on the wait cycle that brings wcnt up to the limit.
                if (r_wcnt >= TMO - 16'd1)
                    r_mem_err <= 1'b1;
            end else begin
                r_wcnt <= '0;
            end

            case (r_state)
                RUN: begin
                    if (!w_mstall && ex_div_valid) begin
                        r_state <= DIV;
                        r_cnt   <= CNT_INIT;
                    end
                end
                DIV: begin
                    if (!w_mstall) begin
                        if (r_cnt != '0)
                            r_cnt <= r_cnt - 8'd1;
                        else
                            r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase

            if (pc_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with DIV_LAT=4, MEM_TIMEOUT=4.
module tb_pipeline_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_div_valid, ex_redirect;
    logic        dmem_req, dmem_ready;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        div_start, div_done, busy, mem_err;
    logic [31:0] stall_cycles;
    logic [10:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    // Output vector: pc,ifid,idex,exmem stalls | ifid,idex,exmem,memwb flushes | start,done,busy
    localparam logic [10:0] IDLE     = 11'b00000000000;
    localparam logic [10:0] LU       = 11'b11000100000;
    localparam logic [10:0] REDIR    = 11'b00001100000;
    localparam logic [10:0] DSTART   = 11'b11100010100;
    localparam logic [10:0] DBUSY    = 11'b11100010001;
    localparam logic [10:0] DDONE    = 11'b00000000011;
    localparam logic [10:0] DDONE_RD = 11'b00001100011;
    localparam logic [10:0] MS_DIV   = 11'b11110001001;
    localparam logic [10:0] MS_RUN   = 11'b11110001000;

    pipeline_ctrl #(.DIV_LAT(4), .MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_div_valid(ex_div_valid), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .div_start(div_start), .div_done(div_done),
        .busy(busy), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                   div_start, div_done, busy};

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_div_valid = 1'b0; ex_redirect = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        ex_div_valid = 1'b1; dmem_req = 1'b1; ex_redirect = 1'b1;
        #3;
        check_eq("rst_outs", 32'(outs), 32'(IDLE));
        check_eq("rst_sc", stall_cycles, 32'd0);
        check_eq("rst_err", 32'(mem_err), 32'd0);
        clear_inputs();
        tick();
        reset = 1'b1;

        // load-use via rs1, then rd=x0, then via rs2, then no use
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
        #1 check_eq("lu_rs1", 32'(outs), 32'(LU));
        tick();
        ex_rd = 5'd0; id_rs1 = 5'd0;
        #1 check_eq("lu_x0", 32'(outs), 32'(IDLE));
        tick();
        ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1; id_rs2 = 5'd7;
        #1 check_eq("lu_rs2", 32'(outs), 32'(LU));
        tick();
        id_use_rs2 = 1'b0;
        #1 check_eq("lu_nouse", 32'(outs), 32'(IDLE));
        tick();
        check_eq("sc_lu", stall_cycles, 32'd2);

        // redirect beats load-use
        id_use_rs2 = 1'b1; ex_redirect = 1'b1;
        #1 check_eq("redir_lu", 32'(outs), 32'(REDIR));
        tick();
        clear_inputs();
        check_eq("sc_redir", stall_cycles, 32'd2);

        // plain divide
        ex_div_valid = 1'b1;
        #1 check_eq("div_t0", 32'(outs), 32'(DSTART));
        tick();
        for (int i = 1; i <= 3; i++) begin
            #1 check_eq($sformatf("div_t%0d", i), 32'(outs), 32'(DBUSY));
            tick();
        end
        #1 check_eq("div_t4", 32'(outs), 32'(DDONE));
        tick();
        ex_div_valid = 1'b0;
        #1 check_eq("div_t5", 32'(outs), 32'(IDLE));
        check_eq("sc_div", stall_cycles, 32'd6);
        tick();

        // divide with 3 memory-wait cycles at t+2; redirect in the done cycle
        ex_div_valid = 1'b1;
        #1 check_eq("dw_t0", 32'(outs), 32'(DSTART));
        tick();
        #1 check_eq("dw_t1", 32'(outs), 32'(DBUSY));
        tick();
        dmem_req = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            #1 check_eq($sformatf("dw_t%0d", i), 32'(outs), 32'(MS_DIV));
            tick();
        end
        dmem_req = 1'b0;
        for (int i = 5; i <= 6; i++) begin
            #1 check_eq($sformatf("dw_t%0d", i), 32'(outs), 32'(DBUSY));
            tick();
        end
        ex_redirect = 1'b1;
        #1 check_eq("dw_t7", 32'(outs), 32'(DDONE_RD));
        tick();
        clear_inputs();
        #1 check_eq("dw_t8", 32'(outs), 32'(IDLE));
        check_eq("sc_dw", stall_cycles, 32'd13);
        check_eq("err_dw", 32'(mem_err), 32'd0);
        tick();

        // memory timeout
        dmem_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            #1 check_eq($sformatf("to_out%0d", k), 32'(outs), 32'(MS_RUN));
            tick();
            check_eq($sformatf("to_err%0d", k), 32'(mem_err), (k >= 4) ? 32'd1 : 32'd0);
        end
        dmem_ready = 1'b1;
        #1 check_eq("to_ready", 32'(outs), 32'(IDLE));
        tick();
        check_eq("to_sticky", 32'(mem_err), 32'd1);
        check_eq("sc_to", stall_cycles, 32'd19);
        clear_inputs();

        // reset during divide with cnt=2
        ex_div_valid = 1'b1;
        tick();
        tick();
        #1 check_eq("rd_cnt2", 32'(outs), 32'(DBUSY));
        reset = 1'b0;
        #1 check_eq("rd_outs", 32'(outs), 32'(IDLE));
        check_eq("rd_sc", stall_cycles, 32'd0);
        check_eq("rd_err", 32'(mem_err), 32'd0);
        tick();
        ex_div_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1 check_eq($sformatf("rd_post%0d", i), 32'(outs), 32'(IDLE));
            tick();
        end
        check_eq("rd_sc_post", stall_cycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
